// File: rtl/pll_lock_supervisor_if.sv
// pll_lock_supervisor_if: PLL-side and downstream signals of the lock supervisor
// Parameter: MAX_RETRIES sizes retry_count as $clog2(MAX_RETRIES+1) bits.
// Signals: pll_locked (async lock flag from PLL), clear_fault (request to leave FAULT),
//   pll_rst (reset to PLL), sys_ready (lock qualified), fault (sticky failure),
//   retry_count (failed attempts), relock_event (lock-loss pulse), lock_loss_cnt (loss tally).
// Modports: master = supervisor, slave = PLL wrapper / downstream consumer.
interface pll_lock_supervisor_if #(
  parameter int MAX_RETRIES = 3
);
  localparam int RC_W = $clog2(MAX_RETRIES + 1);
  logic            pll_locked;
  logic            clear_fault;
  logic            pll_rst;
  logic            sys_ready;
  logic            fault;
  logic [RC_W-1:0] retry_count;
  logic            relock_event;
  logic [7:0]      lock_loss_cnt;
  modport master (
    input  pll_locked, clear_fault,
    output pll_rst, sys_ready, fault, retry_count, relock_event, lock_loss_cnt
  );
  modport slave (
    output pll_locked, clear_fault,
    input  pll_rst, sys_ready, fault, retry_count, relock_event, lock_loss_cnt
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: drives PLL reset, debounces lock, retries on timeout, qualifies sys_ready
// Ports: refclk (sole clock), rst (async active-low reset), bus (pll_lock_supervisor_if.master).
// Optional macro LOCK_LOSS_COUNT_EN: when defined, lock_loss_cnt counts relock events
//   saturating at 255; otherwise it is tied to 0 with no counter flops.
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 17
) (
  input  logic                   refclk,
  input  logic                   rst,
  pll_lock_supervisor_if.master  bus
);
  localparam int RC_W = $clog2(MAX_RETRIES + 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(MAX_RETRIES - 1);

  typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAULT} state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RC_W-1:0]  retry_count_q, retry_count_d;
  logic [1:0]       sync_q, sync_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_ready_q, sys_ready_d;
  logic             fault_q, fault_d;
  logic             relock_event_q, relock_event_d;
  logic             locked_s;

  assign locked_s = sync_q[1];
  assign sync_d   = {sync_q[0], bus.pll_locked};

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q + 1'b1;
    retry_count_d  = retry_count_q;
    relock_event_d = 1'b0;
    case (state_q)
      RESET_PLL: if (cnt_q == RST_LAST) begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
      WAIT_LOCK: if (locked_s) begin
        state_d = STABILIZE;
        cnt_d   = '0;
      end else if (cnt_q == TO_LAST) begin
        retry_count_d = retry_count_q + 1'b1;
        cnt_d         = '0;
        state_d       = (retry_count_q == RC_LAST) ? FAULT : RESET_PLL;
      end
      STABILIZE: if (!locked_s) begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end else if (cnt_q == STB_LAST) begin
        state_d       = RUN;
        cnt_d         = '0;
        retry_count_d = '0;
      end
      RUN: begin
        cnt_d = '0;
        if (!locked_s) begin
          relock_event_d = 1'b1;
          state_d        = RESET_PLL;
        end
      end
      FAULT: begin
        cnt_d = '0;
        if (bus.clear_fault) begin
          state_d       = RESET_PLL;
          retry_count_d = '0;
        end
      end
      default: begin
        state_d = RESET_PLL;
        cnt_d   = '0;
      end
    endcase
    // outputs are registered from the next state so they change on the transition edge
    pll_rst_d   = state_d == RESET_PLL;
    sys_ready_d = state_d == RUN;
    fault_d     = state_d == FAULT;
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q        <= RESET_PLL;
      cnt_q          <= '0;
      retry_count_q  <= '0;
      sync_q         <= '0;
      pll_rst_q      <= 1'b1;
      sys_ready_q    <= 1'b0;
      fault_q        <= 1'b0;
      relock_event_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retry_count_q  <= retry_count_d;
      sync_q         <= sync_d;
      pll_rst_q      <= pll_rst_d;
      sys_ready_q    <= sys_ready_d;
      fault_q        <= fault_d;
      relock_event_q <= relock_event_d;
    end
  end

`ifdef LOCK_LOSS_COUNT_EN
  logic [7:0] lock_loss_cnt_q, lock_loss_cnt_d;
  assign lock_loss_cnt_d = (relock_event_d && lock_loss_cnt_q != 8'hff) ? lock_loss_cnt_q + 8'd1 : lock_loss_cnt_q;
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) lock_loss_cnt_q <= '0;
    else lock_loss_cnt_q <= lock_loss_cnt_d;
  end
  assign bus.lock_loss_cnt = lock_loss_cnt_q;
`else
  assign bus.lock_loss_cnt = '0;
`endif

  assign bus.pll_rst      = pll_rst_q;
  assign bus.sys_ready    = sys_ready_q;
  assign bus.fault        = fault_q;
  assign bus.retry_count  = retry_count_q;
  assign bus.relock_event = relock_event_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: randomized lock/unlock stimulus checked against a phase-level model
module tb_pll_lock_supervisor;
  localparam int RP = 4, ST = 8, TO = 32, MR = 2;
  localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FAULT = 4;

  logic refclk = 1'b0;
  logic rst = 1'b1;
  pll_lock_supervisor_if #(.MAX_RETRIES(MR)) bus();
  pll_lock_supervisor #(
    .RST_PULSE_CYCLES(RP), .LOCK_STABLE_CYCLES(ST), .LOCK_TIMEOUT_CYCLES(TO),
    .MAX_RETRIES(MR), .CNT_W(6)
  ) dut (.refclk(refclk), .rst(rst), .bus(bus));

  always #5 refclk = ~refclk;

  int n_chk = 0, n_fail = 0;
  int ph, t, rc, loss;
  bit h1, h2, rel, seen_run, seen_fault, seen_rel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    ph = P_RST; t = 0; rc = 0; loss = 0; h1 = 0; h2 = 0; rel = 0;
  endtask

  // one refclk edge: the decision uses the synchronized lock seen before the edge
  task automatic model_step();
    bit ls;
    ls = h2; h2 = h1; h1 = bus.pll_locked; rel = 0;
    if (ph == P_RST) begin
      t++;
      if (t == RP) begin ph = P_WAIT; t = 0; end
    end else if (ph == P_WAIT) begin
      if (ls) begin ph = P_STAB; t = 0; end
      else begin
        t++;
        if (t == TO) begin rc++; t = 0; ph = (rc == MR) ? P_FAULT : P_RST; end
      end
    end else if (ph == P_STAB) begin
      if (!ls) begin ph = P_WAIT; t = 0; end
      else begin
        t++;
        if (t == ST) begin ph = P_RUN; rc = 0; t = 0; end
      end
    end else if (ph == P_RUN) begin
      if (!ls) begin
        rel = 1; ph = P_RST; t = 0;
`ifdef LOCK_LOSS_COUNT_EN
        loss = (loss < 255) ? loss + 1 : 255;
`endif
      end
    end else if (bus.clear_fault) begin
      ph = P_RST; rc = 0; t = 0;
    end
    seen_run   |= ph == P_RUN;
    seen_fault |= ph == P_FAULT;
    seen_rel   |= rel;
  endtask

  task automatic check_outputs();
    check("pll_rst", 32'(bus.pll_rst), 32'(ph == P_RST));
    check("sys_ready", 32'(bus.sys_ready), 32'(ph == P_RUN));
    check("fault", 32'(bus.fault), 32'(ph == P_FAULT));
    check("retry_count", 32'(bus.retry_count), rc);
    check("relock_event", 32'(bus.relock_event), 32'(rel));
    check("lock_loss_cnt", 32'(bus.lock_loss_cnt), loss);
  endtask

  task automatic tick();
    @(posedge refclk);
    if (rst) model_step(); else model_reset();
    #1 check_outputs();
    @(negedge refclk);
  endtask

  // reset asserted between edges must clear outputs before the next edge
  task automatic async_reset();
    #2 rst = 1'b0;
    #1 model_reset();
    check_outputs();
    @(negedge refclk);
    @(negedge refclk);
    rst = 1'b1;
  endtask

  initial begin
    int lvl, len;
    bus.pll_locked = 1'b0;
    bus.clear_fault = 1'b0;
    #1 rst = 1'b0;
    #2 model_reset();
    check_outputs();
    repeat (3) @(negedge refclk);
    rst = 1'b1;
    for (int cyc = 0; cyc < 5000;) begin
      lvl = $urandom_range(0, 1);
      len = lvl ? $urandom_range(1, 60) : ($urandom_range(0, 1) ? $urandom_range(1, 6) : $urandom_range(1, 120));
      bus.pll_locked = lvl[0];
      for (int i = 0; i < len; i++) begin
        bus.clear_fault = ($urandom_range(0, 15) == 0);
        tick();
        cyc++;
      end
      bus.clear_fault = 1'b0;
      if ($urandom_range(0, 19) == 0) async_reset();
    end
    bus.clear_fault = 1'b0;
    async_reset();
    for (int k = 0; k < 260; k++) begin
      bus.pll_locked = 1'b1;
      repeat (20) tick();
      bus.pll_locked = 1'b0;
      repeat (3) tick();
    end
    bus.pll_locked = 1'b1;
    repeat (20) tick();
`ifdef LOCK_LOSS_COUNT_EN
    check("loss_final", 32'(bus.lock_loss_cnt), 255);
`else
    check("loss_final", 32'(bus.lock_loss_cnt), 0);
`endif
    check("reached_run", 32'(seen_run), 1);
    check("reached_fault", 32'(seen_fault), 1);
    check("saw_relock", 32'(seen_rel), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
